// File: rtl/mul_24bit_array.sv
// Unsigned 24x24 array multiplier with a registered 48-bit product.
// The datapath has three combinational stages:
//   1. An AND-gate partial-product array.
//   2. A carry-save accumulation, one full-adder row per multiplier bit.
//   3. A final ripple carry-propagate adder.
// The product register gives exactly one cycle of latency.
module mul_24bit_array (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [23:0] in1,
    input  logic [23:0] in2,
    output logic [47:0] out
);

    localparam int unsigned W  = 24;
    localparam int unsigned PW = 48;

    // Partial products: pp[i][j] = in1[j] & in2[i]
    logic [W-1:0]  pp [W];

    // Running carry-save state after each adder row
    logic [PW-1:0] acc_s [W];
    logic [PW-1:0] acc_c [W];
    logic [PW-1:0] row_addend;
    logic [1:0]    row_fa;

    // Final carry-propagate adder signals
    logic [PW-1:0] product;
    logic          cpa_carry;
    logic [1:0]    cpa_fa;

    // One-bit full adder, returns {carry, sum}
    function automatic logic [1:0] full_add(input logic a, input logic b, input logic ci);
        return {(a & b) | (a & ci) | (b & ci), a ^ b ^ ci};
    endfunction

    // AND-gate array: each multiplier bit gates a copy of the multiplicand
    always_comb begin
        pp = '{default: '0};
        for (int unsigned i = 0; i < W; i++) begin
            pp[i] = in1 & {W{in2[i]}};
        end
    end

    // Carry-save rows: row i folds pp[i] << i into the running sum/carry pair.
    // The carry out of bit 47 is dropped; the exact product always fits in 48 bits.
    always_comb begin
        acc_s      = '{default: '0};
        acc_c      = '{default: '0};
        row_addend = '0;
        row_fa     = '0;
        acc_s[0]   = {{W{1'b0}}, pp[0]};
        for (int unsigned i = 1; i < W; i++) begin
            row_addend = {{W{1'b0}}, pp[i]} << i;
            for (int unsigned k = 0; k < PW; k++) begin
                row_fa      = full_add(acc_s[i-1][k], acc_c[i-1][k], row_addend[k]);
                acc_s[i][k] = row_fa[0];
                if (k < PW - 1) begin
                    acc_c[i][k+1] = row_fa[1];
                end
            end
        end
    end

    // Ripple carry-propagate adder resolving the final sum/carry pair
    always_comb begin
        product   = '0;
        cpa_carry = 1'b0;
        cpa_fa    = '0;
        for (int unsigned k = 0; k < PW; k++) begin
            cpa_fa     = full_add(acc_s[W-1][k], acc_c[W-1][k], cpa_carry);
            product[k] = cpa_fa[0];
            cpa_carry  = cpa_fa[1];
        end
    end

    // Output register; asynchronous reset clears the product immediately
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out <= '0;
        end else begin
            out <= product;
        end
    end

endmodule

// File: tb/tb_mul_24bit_array.sv
// Self-checking bench for mul_24bit_array: directed vectors, reset corner
// cases, an incrementing sweep through the 24-bit wrap, glitch/latency
// checks and random operands against an arithmetic reference.
module tb_mul_24bit_array;

    logic        clk;
    logic        rst_n;
    logic [23:0] in1;
    logic [23:0] in2;
    logic [47:0] out;

    int errors;
    int checks;

    typedef struct {
        logic [23:0] a;
        logic [23:0] b;
        logic [47:0] p;
    } vec_t;

    vec_t vecs [12];

    mul_24bit_array dut (
        .clk   (clk),
        .rst_n (rst_n),
        .in1   (in1),
        .in2   (in2),
        .out   (out)
    );

    // 10 ns clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard time limit so the run always terminates
    initial begin
        #2_000_000;
        $display("FAIL timeout: bench exceeded time limit, got checks=%0d required completion", checks);
        $fatal(1, "timeout");
    end

    function automatic logic [47:0] ref_mul(input logic [23:0] a, input logic [23:0] b);
        logic [47:0] ea;
        logic [47:0] eb;
        ea = {24'h0, a};
        eb = {24'h0, b};
        return ea * eb;
    endfunction

    task automatic check(input string name, input logic [47:0] act, input logic [47:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%012h required 0x%012h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Wait for the next rising edge and settle 1 ns past it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [23:0] a;
        logic [23:0] b;
        logic [23:0] v;
        logic [47:0] held;

        errors = 0;
        checks = 0;

        vecs[0]  = '{a: 24'h000003, b: 24'h000005, p: 48'h00000000000F};
        vecs[1]  = '{a: 24'h800000, b: 24'h000002, p: 48'h000001000000};
        vecs[2]  = '{a: 24'h000000, b: 24'hABCDEF, p: 48'h000000000000};
        vecs[3]  = '{a: 24'h000001, b: 24'hABCDEF, p: 48'h000000ABCDEF};
        vecs[4]  = '{a: 24'hABCDEF, b: 24'h000001, p: 48'h000000ABCDEF};
        vecs[5]  = '{a: 24'hFFFF00, b: 24'hFFFF00, p: 48'hFFFE00010000};
        vecs[6]  = '{a: 24'hFFFF01, b: 24'hFFFF01, p: 48'hFFFE0200FE01};
        vecs[7]  = '{a: 24'hFFFFFF, b: 24'hFFFFFF, p: 48'hFFFFFE000001};
        vecs[8]  = '{a: 24'h800000, b: 24'h800000, p: 48'h400000000000};
        vecs[9]  = '{a: 24'h123456, b: 24'h000100, p: 48'h000012345600};
        vecs[10] = '{a: 24'h001000, b: 24'h001000, p: 48'h000001000000};
        vecs[11] = '{a: 24'hFFFFFF, b: 24'h000000, p: 48'h000000000000};

        // Reset held with all-ones operands and clock running
        rst_n = 1'b0;
        in1   = 24'hFFFFFF;
        in2   = 24'hFFFFFF;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("reset_hold", out, 48'h0);
        end

        // First edge after release captures the operands present
        #1;
        rst_n = 1'b1;
        tick();
        check("reset_release", out, 48'hFFFFFE000001);

        // Directed vectors, one per cycle, back to back
        for (int i = 0; i < 12; i++) begin
            in1 = vecs[i].a;
            in2 = vecs[i].b;
            tick();
            check($sformatf("vec%0d", i), out, vecs[i].p);
        end

        // Asynchronous reset mid-cycle after a nonzero product
        in1 = 24'h123456;
        in2 = 24'h654321;
        tick();
        check("pre_async", out, ref_mul(24'h123456, 24'h654321));
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset", out, 48'h0);
        tick();
        check("reset_midstream_hold", out, 48'h0);
        #1;
        rst_n = 1'b1;
        in1   = 24'hABCDEF;
        in2   = 24'h000003;
        tick();
        check("release_capture", out, ref_mul(24'hABCDEF, 24'h000003));

        // Incrementing sweep through the 24-bit wrap
        v = 24'hFFFF00;
        for (int i = 0; i < 512; i++) begin
            in1 = v;
            in2 = v;
            tick();
            check("sweep", out, ref_mul(v, v));
            if (v == 24'hFFFFFF) begin
                check("sweep_wrap_max", out, 48'hFFFFFE000001);
            end
            if (v == 24'h000000) begin
                check("sweep_wrap_zero", out, 48'h0);
            end
            v = v + 24'h1;
        end

        // Inputs toggled between edges must not reach out until the next edge
        for (int r = 0; r < 4; r++) begin
            a = 24'($urandom);
            b = 24'($urandom);
            in1 = a;
            in2 = b;
            tick();
            held = ref_mul(a, b);
            check("glitch_base", out, held);
            for (int g = 0; g < 4; g++) begin
                in1 = 24'($urandom);
                in2 = 24'($urandom);
                #1;
                check("glitch_hold", out, held);
            end
            a = 24'($urandom);
            b = 24'($urandom);
            in1 = a;
            in2 = b;
            tick();
            check("glitch_capture", out, ref_mul(a, b));
        end

        // Random operands, one pair per cycle, with occasional extreme values
        for (int i = 0; i < 20000; i++) begin
            case ($urandom_range(0, 15))
                0:       a = 24'hFFFFFF;
                1:       a = 24'h000000;
                default: a = 24'($urandom);
            endcase
            case ($urandom_range(0, 15))
                0:       b = 24'hFFFFFF;
                1:       b = 24'h000001;
                default: b = 24'($urandom);
            endcase
            in1 = a;
            in2 = b;
            tick();
            check("random", out, ref_mul(a, b));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
